// File: rtl/posit_accum_ctrl.sv
// Reduces each s_last-delimited group of posits to one sum by sequencing an external posit adder.
// Optional POSIT_ACC_COUNT_EN adds m_count, the saturating operand count of the group.
module posit_accum_ctrl #(
    parameter int N     = 32,
    parameter int es    = 2,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N-1:0]     s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [N-1:0]     add_in1,
    output logic [N-1:0]     add_in2,
    output logic             add_start,
    input  logic [N-1:0]     add_result,
    input  logic             add_inf,
    input  logic             add_zero,
    input  logic             add_done,
    output logic [N-1:0]     m_data,
    output logic             m_inf,
    output logic             m_zero,
    output logic             m_valid,
`ifdef POSIT_ACC_COUNT_EN
    output logic [CNT_W-1:0] m_count,
`endif
    input  logic             m_ready
);

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    if (CNT_W < 1 || es < 0 || es > N - 3) begin : g_bad_params
        $error("posit_accum_ctrl: invalid parameter combination");
    end

    typedef enum logic [2:0] {IDLE, FIRST, NEXT, ISSUE, WAIT, OUT} state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] acc;
    logic [N-1:0] op;
    logic         nar;
    logic         zero;
    logic         last_q;
`ifdef POSIT_ACC_COUNT_EN
    logic [CNT_W-1:0] cnt;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = FIRST;
            FIRST: if (s_valid) state_next = s_last ? OUT : NEXT;
            NEXT: begin
                if (s_valid) begin
                    if (nar || s_data == NAR) state_next = s_last ? OUT : NEXT;
                    else                      state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT:  if (add_done) state_next = last_q ? OUT : NEXT;
            OUT:   if (m_ready) state_next = FIRST;
            default: state_next = IDLE;
        endcase
    end

    // zero tracks acc==0 via the adder's own flag instead of a wide compare of acc
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            acc     <= '0;
            op      <= '0;
            nar     <= 1'b0;
            zero    <= 1'b0;
            last_q  <= 1'b0;
`ifdef POSIT_ACC_COUNT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_next;
            s_ready <= (state_next == FIRST) || (state_next == NEXT);
            case (state)
                FIRST: begin
                    if (s_valid) begin
                        acc  <= s_data;
                        nar  <= (s_data == NAR);
                        zero <= (s_data == '0);
`ifdef POSIT_ACC_COUNT_EN
                        cnt  <= CNT_W'(1);
`endif
                    end
                end
                NEXT: begin
                    if (s_valid) begin
                        op     <= s_data;
                        last_q <= s_last;
                        if (s_data == NAR) nar <= 1'b1;
`ifdef POSIT_ACC_COUNT_EN
                        if (cnt != '1) cnt <= cnt + CNT_W'(1);
`endif
                    end
                end
                WAIT: begin
                    if (add_done) begin
                        acc  <= add_result;
                        zero <= add_zero;
                        if (add_inf) nar <= 1'b1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        acc  <= '0;
                        nar  <= 1'b0;
                        zero <= 1'b0;
`ifdef POSIT_ACC_COUNT_EN
                        cnt  <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign add_in1   = acc;
    assign add_in2   = op;
    assign add_start = (state == ISSUE);
    assign m_valid   = (state == OUT);
    assign m_data    = !m_valid ? '0 : (nar ? NAR : acc);
    assign m_inf     = m_valid && nar;
    assign m_zero    = m_valid && !nar && zero;
`ifdef POSIT_ACC_COUNT_EN
    assign m_count   = cnt;
`endif

endmodule

// File: tb/tb_posit_accum_ctrl.sv
// Directed bench for posit_accum_ctrl with a fixed-latency table-driven posit adder model.
// Build with POSIT_ACC_COUNT_EN defined to also check m_count.
module tb_posit_accum_ctrl;

    localparam int L = 4;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic        add_start;
    logic [31:0] add_result;
    logic        add_inf;
    logic        add_zero;
    logic        add_done;
    logic [31:0] m_data;
    logic        m_inf;
    logic        m_zero;
    logic        m_valid;
    logic        m_ready;
`ifdef POSIT_ACC_COUNT_EN
    logic [15:0] m_count;
`endif

    posit_accum_ctrl #(.N(32), .es(2), .CNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
        .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
        .m_data(m_data), .m_inf(m_inf), .m_zero(m_zero), .m_valid(m_valid),
`ifdef POSIT_ACC_COUNT_EN
        .m_count(m_count),
`endif
        .m_ready(m_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hand-computed posit<32,2> sums for the operand pairs used below.
    function automatic logic [31:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4800_0000; // 1+1
        if (a == 32'h4000_0000 && b == 32'hC000_0000) return 32'h0000_0000; // 1-1
        if (a == 32'h2CCC_CCCD && b == 32'h2CCC_CCCD) return 32'h34CC_CCCD; // 0.2+0.2
        if (a == 32'h34CC_CCCD && b == 32'h2CCC_CCCD) return 32'h3999_999A; // 0.4+0.2
        return 32'hDEAD_BEEF;
    endfunction

    int          starts = 0;
    int          busy   = 0;
    logic [31:0] la, lb;
    logic [31:0] pin1 [0:31];
    logic [31:0] pin2 [0:31];

    always @(posedge aclk) begin
        add_done <= 1'b0;
        if (add_start) begin
            pin1[starts[4:0]] <= add_in1;
            pin2[starts[4:0]] <= add_in2;
            la     <= add_in1;
            lb     <= add_in2;
            starts <= starts + 1;
            busy   <= L;
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
                add_done   <= 1'b1;
                add_result <= ref_sum(la, lb);
                add_inf    <= (ref_sum(la, lb) == 32'h8000_0000);
                add_zero   <= (ref_sum(la, lb) == 32'h0000_0000);
            end
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        while (s_ready !== 1'b1 && n < 200) begin
            @(posedge aclk); #1; n++;
        end
        if (n >= 200) chk("accept timeout s_ready", 32'(s_ready), 32'd1);
        @(posedge aclk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (m_valid !== 1'b1 && n < 200) begin
            @(posedge aclk); #1; n++;
        end
        if (n >= 200) chk("m_valid timeout", 32'(m_valid), 32'd1);
    endtask

    task automatic take();
        m_ready = 1'b1;
        @(posedge aclk); #1;
        m_ready = 1'b0;
        chk("m_valid drop after handshake", 32'(m_valid), 32'd0);
        chk("s_ready after handshake", 32'(s_ready), 32'd1);
    endtask

    task automatic chk_count(input int exp);
`ifdef POSIT_ACC_COUNT_EN
        chk("m_count", 32'(m_count), 32'(exp));
`else
        if (exp < 0) chk("m_count negative", 32'(exp), 32'd0);
`endif
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, " add_start"}, 32'(add_start), 32'd0);
        chk({tag, " add_in1"}, add_in1, 32'd0);
        chk({tag, " add_in2"}, add_in2, 32'd0);
        chk({tag, " m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, " m_data"}, m_data, 32'd0);
        chk({tag, " m_inf"}, 32'(m_inf), 32'd0);
        chk({tag, " m_zero"}, 32'(m_zero), 32'd0);
        chk_count(0);
    endtask

    initial begin
        int n;
        int s0;
        aresetn = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_outputs("reset");
        aresetn = 1'b1;

        // single-operand group: result one cycle after accept, adder untouched
        s0 = starts;
        send(32'h4000_0000, 1'b1);
        chk("single m_valid latency", 32'(m_valid), 32'd1);
        chk("single m_data", m_data, 32'h4000_0000);
        chk("single m_inf", 32'(m_inf), 32'd0);
        chk("single m_zero", 32'(m_zero), 32'd0);
        chk("single s_ready in OUT", 32'(s_ready), 32'd0);
        chk("single add_start count", 32'(starts - s0), 32'd0);
        chk_count(1);
        take();

        // two operands: one add, 2+L cycles from final accept to m_valid
        s0 = starts;
        send(32'h4000_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        wait_valid(n);
        chk("pair latency", 32'(n), 32'(2 + L));
        chk("pair add_start count", 32'(starts - s0), 32'd1);
        chk("pair add_in1", pin1[s0[4:0]], 32'h4000_0000);
        chk("pair add_in2", pin2[s0[4:0]], 32'h4000_0000);
        chk("pair m_data", m_data, 32'h4800_0000);
        chk("pair m_zero", 32'(m_zero), 32'd0);
        chk_count(2);
        take();

        // three operands: second add chains the first result
        s0 = starts;
        send(32'h2CCC_CCCD, 1'b0);
        send(32'h2CCC_CCCD, 1'b0);
        send(32'h2CCC_CCCD, 1'b1);
        wait_valid(n);
        chk("triple add_start count", 32'(starts - s0), 32'd2);
        chk("triple first add_in1", pin1[s0[4:0]], 32'h2CCC_CCCD);
        chk("triple second add_in1", pin1[5'(s0 + 1)], 32'h34CC_CCCD);
        chk("triple second add_in2", pin2[5'(s0 + 1)], 32'h2CCC_CCCD);
        chk("triple m_data", m_data, 32'h3999_999A);
        chk("triple m_inf", 32'(m_inf), 32'd0);
        chk_count(3);
        take();

        // NaR poisons the group: adder skipped, one cycle per skipped operand
        s0 = starts;
        send(32'h4000_0000, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        chk("nar m_valid latency", 32'(m_valid), 32'd1);
        chk("nar add_start count", 32'(starts - s0), 32'd0);
        chk("nar m_inf", 32'(m_inf), 32'd1);
        chk("nar m_data", m_data, 32'h8000_0000);
        chk("nar m_zero", 32'(m_zero), 32'd0);
        chk_count(3);
        take();

        // cancelling operands produce a zero sum
        send(32'h4000_0000, 1'b0);
        send(32'hC000_0000, 1'b1);
        wait_valid(n);
        chk("zero m_data", m_data, 32'h0000_0000);
        chk("zero m_zero", 32'(m_zero), 32'd1);
        chk("zero m_inf", 32'(m_inf), 32'd0);
        take();

        // back-pressure: output held, next operand waits for the handshake
        send(32'h4000_0000, 1'b1);
        s_data  = 32'h4800_0000;
        s_valid = 1'b1;
        s_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall m_data", m_data, 32'h4000_0000);
            chk("stall m_valid", 32'(m_valid), 32'd1);
            chk("stall s_ready", 32'(s_ready), 32'd0);
            @(posedge aclk); #1;
        end
        m_ready = 1'b1;
        @(posedge aclk); #1;
        m_ready = 1'b0;
        chk("post-stall m_valid", 32'(m_valid), 32'd0);
        send(32'h4800_0000, 1'b1);
        chk("post-stall group m_valid", 32'(m_valid), 32'd1);
        chk("post-stall group m_data", m_data, 32'h4800_0000);
        chk_count(1);
        take();

        // reset while waiting on the adder; its late done must be ignored
        send(32'h4000_0000, 1'b0);
        send(32'h4000_0000, 1'b1);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        chk_reset_outputs("mid reset");
        aresetn = 1'b1;
        repeat (6) @(posedge aclk);
        #1;
        chk("stale done m_valid", 32'(m_valid), 32'd0);
        chk("stale done s_ready", 32'(s_ready), 32'd1);
        chk("stale done add_start", 32'(add_start), 32'd0);
        send(32'hC000_0000, 1'b1);
        chk("after reset m_valid", 32'(m_valid), 32'd1);
        chk("after reset m_data", m_data, 32'hC000_0000);
        chk("after reset m_inf", 32'(m_inf), 32'd0);
        chk("after reset m_zero", 32'(m_zero), 32'd0);
        chk_count(1);
        take();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
